// File: rtl/syn_array_seq_if.sv
// Control bundle between the layer controller, the synapse-array sequencer and the array.
// master = controller/array side, slave = sequencer.
interface syn_array_seq_if #(
   parameter int ROWS   = 8,
   parameter int CLMS   = 8,
   parameter int ADDR_W = 8,
   parameter int CFG_W  = 16,
   parameter int STEP_W = 8
);
   logic              start;
   logic              abort;
   logic [STEP_W-1:0] n_steps;
   logic [ADDR_W-1:0] rd_base;
   logic [ADDR_W-1:0] wr_base;
   logic [CFG_W-1:0]  cfg_word;
   logic              busy;
   logic              done;
   logic [CFG_W-1:0]  cfgdat;
   logic [ROWS-1:0]   row_en;
   logic [CLMS-1:0]   clm_en;
   logic [ROWS-1:0]   row_rd;
   logic [CLMS-1:0]   clm_rd;
   logic              rtm_en;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr;

   modport master (
      output start, abort, n_steps, rd_base, wr_base, cfg_word,
      input  busy, done, cfgdat, row_en, clm_en, row_rd, clm_rd, rtm_en, r_addr, w_addr
   );

   modport slave (
      input  start, abort, n_steps, rd_base, wr_base, cfg_word,
      output busy, done, cfgdat, row_en, clm_en, row_rd, clm_rd, rtm_en, r_addr, w_addr
   );
endinterface

// File: rtl/syn_array_seq.sv
// Layer sequencer for a ROWS x CLMS synapse grid: config broadcast, skewed MAC wavefront,
// then row-by-row write-back. All outputs are registered from the next-state values.
module syn_array_seq #(
   parameter int ROWS   = 8,
   parameter int CLMS   = 8,
   parameter int ADDR_W = 8,
   parameter int CFG_W  = 16,
   parameter int STEP_W = 8
) (
   input  logic clk,
   input  logic rst,
   syn_array_seq_if.slave bus
);

   localparam int MAXD  = (ROWS > CLMS) ? ROWS : CLMS;
   localparam int CNT_W = STEP_W + 2 + $clog2(MAXD);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] RUN  = 3'd2;
   localparam logic [2:0] WB   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]        state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d, run_last;
   logic [STEP_W-1:0] n_q, n_d;
   logic [ADDR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CFG_W-1:0]  cfg_q, cfg_d;

   logic              busy_q, busy_d, done_q, done_d, rtm_en_q, rtm_en_d;
   logic [CFG_W-1:0]  cfgdat_q, cfgdat_d;
   logic [ROWS-1:0]   row_en_q, row_en_d, row_rd_q, row_rd_d;
   logic [CLMS-1:0]   clm_en_q, clm_en_d, clm_rd_q, clm_rd_d;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;

   // Last RUN step index: n_steps + max(ROWS,CLMS) - 2 (n_steps is never 0 in RUN).
   assign run_last = CNT_W'(n_q) + CNT_W'(MAXD) - CNT_W'(2);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      n_d     = n_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cfg_d   = cfg_q;
      if (bus.abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               n_d     = bus.n_steps;
               rd_d    = bus.rd_base;
               wr_d    = bus.wr_base;
               cfg_d   = bus.cfg_word;
               cnt_d   = '0;
               state_d = (bus.n_steps == '0) ? DONE : LOAD;
            end
            LOAD: begin
               state_d = RUN;
               cnt_d   = '0;
            end
            RUN: if (cnt == run_last) begin
               state_d = WB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
            WB: if (cnt == CNT_W'(ROWS - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output values are decoded from the state/counter about to be entered.
   always_comb begin
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      cfgdat_d = '0;
      row_en_d = '0;
      clm_en_d = '0;
      row_rd_d = '0;
      clm_rd_d = '0;
      rtm_en_d = 1'b0;
      r_addr_d = r_addr_q;
      w_addr_d = w_addr_q;
      case (state_d)
         LOAD: begin
            cfgdat_d = cfg_d;
            r_addr_d = rd_d;
         end
         RUN: begin
            cfgdat_d = cfg_d;
            for (int unsigned i = 0; i < ROWS; i++)
               row_en_d[i] = (cnt_d >= CNT_W'(i)) && (cnt_d < CNT_W'(i) + CNT_W'(n_d));
            for (int unsigned j = 0; j < CLMS; j++)
               clm_en_d[j] = (cnt_d >= CNT_W'(j)) && (cnt_d < CNT_W'(j) + CNT_W'(n_d));
            r_addr_d = rd_d + ADDR_W'(cnt_d);
         end
         WB: begin
            cfgdat_d            = cfg_d;
            cfgdat_d[CFG_W-1]   = 1'b0;
            row_rd_d            = ROWS'(1) << cnt_d;
            clm_rd_d            = '1;
            rtm_en_d            = 1'b1;
            w_addr_d            = wr_d + ADDR_W'(cnt_d);
         end
         DONE: begin
            // Config stays visible through DONE, but with exe_en cleared.
            cfgdat_d          = cfg_d;
            cfgdat_d[CFG_W-1] = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         n_q      <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
         cfg_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cfgdat_q <= '0;
         row_en_q <= '0;
         clm_en_q <= '0;
         row_rd_q <= '0;
         clm_rd_q <= '0;
         rtm_en_q <= 1'b0;
         r_addr_q <= '0;
         w_addr_q <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         n_q      <= n_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         cfg_q    <= cfg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cfgdat_q <= cfgdat_d;
         row_en_q <= row_en_d;
         clm_en_q <= clm_en_d;
         row_rd_q <= row_rd_d;
         clm_rd_q <= clm_rd_d;
         rtm_en_q <= rtm_en_d;
         r_addr_q <= r_addr_d;
         w_addr_q <= w_addr_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.cfgdat = cfgdat_q;
   assign bus.row_en = row_en_q;
   assign bus.clm_en = clm_en_q;
   assign bus.row_rd = row_rd_q;
   assign bus.clm_rd = clm_rd_q;
   assign bus.rtm_en = rtm_en_q;
   assign bus.r_addr = r_addr_q;
   assign bus.w_addr = w_addr_q;

endmodule
